// File: rtl/sram_mem_controller_if.sv
// ---------------------------------------------------------------------------
// sram_mem_controller_if
// Bundles the pipeline-side request/response signals and the external
// 16-bit asynchronous SRAM pins of sram_mem_controller.
//
//   slave  : the controller itself
//   master : the surrounding pipeline plus the SRAM device
//
// Signals
//   wr_en, rd_en          store / load request from EXEMEM
//   address, write_data   byte address and store data
//   read_data             registered load result
//   ready, freeze         access complete / pipeline hold
//   sram_address          SRAM halfword address (SRAM_AW bits)
//   sram_dq_out/oe/in     SRAM data bus, split for an external tri-state pad
//   sram_we_n             SRAM write strobe, active-low
//   addr_error            out-of-range access flag
// ---------------------------------------------------------------------------
interface sram_mem_controller_if #(
   parameter int SRAM_AW = 18
);
   logic                wr_en;
   logic                rd_en;
   logic [31:0]         address;
   logic [31:0]         write_data;
   logic [31:0]         read_data;
   logic                ready;
   logic                freeze;
   logic [SRAM_AW-1:0]  sram_address;
   logic [15:0]         sram_dq_out;
   logic                sram_dq_oe;
   logic [15:0]         sram_dq_in;
   logic                sram_we_n;
   logic                addr_error;

   modport slave (
      input  wr_en, rd_en, address, write_data, sram_dq_in,
      output read_data, ready, freeze, sram_address, sram_dq_out,
             sram_dq_oe, sram_we_n, addr_error
   );

   modport master (
      output wr_en, rd_en, address, write_data, sram_dq_in,
      input  read_data, ready, freeze, sram_address, sram_dq_out,
             sram_dq_oe, sram_we_n, addr_error
   );
endinterface

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
// Runs each MEM-stage 32-bit load/store as two halfword phases (low, then
// high) on a 16-bit asynchronous SRAM, each phase lasting WAIT_CYCLES+1
// cycles. freeze holds the pipeline until the one-cycle ready in DONE.
//
// Ports
//   clock   system clock, rising edge
//   reset   asynchronous, active-high; aborts any access in flight
//   bus     sram_mem_controller_if.slave (pipeline request/response + SRAM pins)
//
// Parameters
//   BASE_ADDR    byte address mapped to SRAM word 0
//   WAIT_CYCLES  extra cycles per halfword phase, 0..15
//   SRAM_AW      SRAM halfword address width
//
// Build option
//   SRAM_RANGE_CHECK_EN  when defined, requests below BASE_ADDR or beyond the
//                        SRAM go straight to DONE with addr_error=1 and no
//                        SRAM activity. Otherwise addresses wrap silently.
//
// state | meaning
// IDLE  | no access; ready = ~(rd_en|wr_en); latches a new request
// LO    | low halfword phase at {word,0}
// HI    | high halfword phase at {word,1}
// DONE  | ready=1 for one cycle, strobes released, pipeline advances
// ---------------------------------------------------------------------------
module sram_mem_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 1,
   parameter int SRAM_AW     = 18
) (
   input logic                  clock,
   input logic                  reset,
   sram_mem_controller_if.slave bus
);
   localparam logic [31:0] BASE      = 32'(BASE_ADDR);
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
   localparam int          WW        = SRAM_AW - 1;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                op_wr_q;
   logic [WW-1:0]       word_q;
   logic [31:0]         wdata_q;
   logic [31:0]         read_data_q;
   logic [SRAM_AW-1:0]  sram_address_q, sram_address_d;
   logic [15:0]         dq_out_q, dq_out_d;
   logic                dq_oe_q, dq_oe_d;
   logic                we_n_q, we_n_d;
   logic                addr_error_q, addr_error_d;

   logic                ready_c;
   logic                latch_req;
   logic                cap_lo;
   logic                cap_hi;
   logic                req;
   logic [31:0]         offset;
   logic [WW-1:0]       word_in;
   logic                range_bad;
   logic                op_wr_next;
   logic [WW-1:0]       word_next;
   logic [31:0]         wdata_next;
   logic                drive_wr;

   assign req     = bus.rd_en | bus.wr_en;
   // Wraps mod 2^32 for addresses below BASE; the cast truncates to the SRAM.
   assign offset  = bus.address - BASE;
   assign word_in = WW'(offset >> 2);

`ifdef SRAM_RANGE_CHECK_EN
   assign range_bad = (bus.address < BASE) || ((offset >> 2) >= (32'd1 << WW));
`else
   assign range_bad = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ready_c      = 1'b0;
      latch_req    = 1'b0;
      cap_lo       = 1'b0;
      cap_hi       = 1'b0;
      addr_error_d = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = ~req;
            if (req) begin
               latch_req = 1'b1;
               cnt_d     = '0;
               if (range_bad) begin
                  state_d      = DONE;
                  addr_error_d = 1'b1;
               end else begin
                  state_d = LO;
               end
            end
         end
         LO: begin
            if (cnt_q == WAIT_LAST) begin
               cap_lo  = ~op_wr_q;
               cnt_d   = '0;
               state_d = HI;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HI: begin
            if (cnt_q == WAIT_LAST) begin
               cap_hi  = ~op_wr_q;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            ready_c = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // SRAM pins are registered from the next state so they switch together
   // with the state register and never glitch; wr_en wins over rd_en.
   always_comb begin
      op_wr_next     = latch_req ? bus.wr_en : op_wr_q;
      word_next      = latch_req ? word_in : word_q;
      wdata_next     = latch_req ? bus.write_data : wdata_q;
      drive_wr       = op_wr_next & ((state_d == LO) | (state_d == HI));
      sram_address_d = sram_address_q;
      if (state_d == LO) begin
         sram_address_d = {word_next, 1'b0};
      end else if (state_d == HI) begin
         sram_address_d = {word_next, 1'b1};
      end
      dq_out_d = '0;
      if (drive_wr) begin
         dq_out_d = (state_d == HI) ? wdata_next[31:16] : wdata_next[15:0];
      end
      dq_oe_d = drive_wr;
      we_n_d  = ~drive_wr;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q          <= '0;
         op_wr_q        <= 1'b0;
         word_q         <= '0;
         wdata_q        <= '0;
         read_data_q    <= '0;
         sram_address_q <= '0;
         dq_out_q       <= '0;
         dq_oe_q        <= 1'b0;
         we_n_q         <= 1'b1;
         addr_error_q   <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         sram_address_q <= sram_address_d;
         dq_out_q       <= dq_out_d;
         dq_oe_q        <= dq_oe_d;
         we_n_q         <= we_n_d;
         addr_error_q   <= addr_error_d;
         if (latch_req) begin
            op_wr_q <= bus.wr_en;
            word_q  <= word_in;
            wdata_q <= bus.write_data;
         end
         if (cap_lo) begin
            read_data_q[15:0] <= bus.sram_dq_in;
         end
         if (cap_hi) begin
            read_data_q[31:16] <= bus.sram_dq_in;
         end
      end
   end

   assign bus.read_data    = read_data_q;
   assign bus.ready        = ready_c;
   assign bus.freeze       = req & ~ready_c;
   assign bus.sram_address = sram_address_q;
   assign bus.sram_dq_out  = dq_out_q;
   assign bus.sram_dq_oe   = dq_oe_q;
   assign bus.sram_we_n    = we_n_q;
   assign bus.addr_error   = addr_error_q;

endmodule
